// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Round-robin Wishbone arbiter granting one of NUM_M masters
//                access to a single slave. Optional stall watchdog enabled by
//                defining WB_ARB_TIMEOUT_EN (force-terminates a transfer with
//                an error after TIMEOUT stalled cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int NUM_M   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_M-1:0]           m_cyc_i,
    input  logic [NUM_M-1:0]           m_stb_i,
    output logic [NUM_M-1:0]           m_ack_o,
    output logic [NUM_M-1:0]           m_err_o,
    output logic [NUM_M-1:0]           gnt_o,
    output logic [$clog2(NUM_M)-1:0]   owner_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    output logic                       timeout_o
);

    localparam int            OW       = $clog2(NUM_M);
    localparam logic [OW:0]   C_NUM_M  = (OW+1)'(NUM_M);

    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_GRANT = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0]    ST_TERM  = 2'd2;
    localparam logic [15:0]   C_LIMIT  = 16'(TIMEOUT - 1);
`endif

    logic [1:0]        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_owner_q, last_owner_d;
    logic [NUM_M-1:0]  gnt_q, gnt_d;

    logic              rr_found;
    logic [OW:0]       rr_sum;
    logic [OW-1:0]     rr_cand;
    logic [OW-1:0]     rr_win;
    logic [NUM_M-1:0]  rr_gnt;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0]       stall_q, stall_d;
    logic              stalled;
`else
    logic              unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Round-robin search starting one past the last owner, wrapping at NUM_M
    always_comb begin
        rr_found = 1'b0;
        rr_win   = last_owner_q;
        rr_sum   = '0;
        rr_cand  = '0;
        rr_gnt   = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            rr_sum = {1'b0, last_owner_q} + (OW+1)'(i);
            if (rr_sum >= C_NUM_M) begin
                rr_sum = rr_sum - C_NUM_M;
            end
            rr_cand = rr_sum[OW-1:0];
            if (!rr_found && m_cyc_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand;
            end
        end
        rr_gnt[rr_win] = 1'b1;
    end

    // Slave/master routing: only the owner sees the bus while granted
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state_q == ST_GRANT) begin
            s_cyc_o          = m_cyc_i[owner_q];
            s_stb_o          = m_stb_i[owner_q];
            // An error takes precedence over a simultaneous ack
            m_ack_o[owner_q] = s_ack_i & ~s_err_i;
            m_err_o[owner_q] = s_err_i;
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (state_q == ST_TERM) begin
            m_err_o[owner_q] = 1'b1;
        end
`endif
    end

`ifdef WB_ARB_TIMEOUT_EN
    assign stalled   = s_stb_o & ~s_ack_i & ~s_err_i;
    assign timeout_o = (state_q == ST_TERM);
`else
    assign timeout_o = 1'b0;
`endif

    // Next-state logic: grant on request, release when the owner drops CYC
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
`ifdef WB_ARB_TIMEOUT_EN
        stall_d      = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_d      = ST_GRANT;
                    owner_d      = rr_win;
                    last_owner_d = rr_win;
                    gnt_d        = rr_gnt;
                end
            end
            ST_GRANT: begin
                if (!m_cyc_i[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (stalled) begin
                    if (stall_q == C_LIMIT) begin
                        state_d = ST_TERM;
                        gnt_d   = '0;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_TERM: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; master 0 wins first after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_M - 1);
            gnt_q        <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            stall_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
`ifdef WB_ARB_TIMEOUT_EN
            stall_q      <= stall_d;
`endif
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter (NUM_M=4, TIMEOUT=8).
//                Expected grants are queued when requests are driven and
//                popped when the arbiter issues a grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int NUM_M = 4;
    localparam int BOUND = 20;

    logic             clk;
    logic             rst_n;
    logic [NUM_M-1:0] m_cyc_i;
    logic [NUM_M-1:0] m_stb_i;
    logic [NUM_M-1:0] m_ack_o;
    logic [NUM_M-1:0] m_err_o;
    logic [NUM_M-1:0] gnt_o;
    logic [1:0]       owner_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_ack_i;
    logic             s_err_i;
    logic             timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NUM_M-1:0] exp_q[$];

    wb_arbiter #(.NUM_M(NUM_M), .TIMEOUT(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .gnt_o     (gnt_o),
        .owner_o   (owner_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] idx_of(input logic [NUM_M-1:0] oh);
        logic [31:0] r = 0;
        for (int i = 0; i < NUM_M; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant, then pops and compares the expected one
    task automatic expect_grant(input string tag, input int exp_lat);
        int waited = -1;
        logic [NUM_M-1:0] exp;
        for (int c = 1; c <= BOUND; c++) begin
            tick();
            if (gnt_o != '0) begin
                waited = c;
                break;
            end
        end
        check_val({tag, "_latency"}, waited, exp_lat);
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check_val({tag, "_gnt"}, gnt_o, exp);
            check_val({tag, "_owner"}, owner_o, idx_of(exp));
        end
    endtask

    // Grant must never have more than one bit set
    always @(negedge clk) begin
        check_val("gnt_onehot", $onehot0(gnt_o), 1);
    end

    initial begin
        rst_n   = 1'b0;
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        tick();
        tick();
        check_val("rst_gnt", gnt_o, 0);
        check_val("rst_owner", owner_o, 0);
        check_val("rst_s_cyc", s_cyc_o, 0);
        check_val("rst_timeout", timeout_o, 0);

        // Round robin with all masters requesting
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        rst_n   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [NUM_M-1:0] g;
            expect_grant("rr", 1);
            g = gnt_o;
            check_val("rr_s_cyc", s_cyc_o, 1);
            s_ack_i = 1'b1;
            #1;
            check_val("rr_ack", m_ack_o, g);
            tick();
            s_ack_i = 1'b0;
            m_cyc_i = 4'b1111 & ~g;
            tick();
            check_val("rr_idle_gap", gnt_o, 0);
            if (k < 4) m_cyc_i = 4'b1111;
            else       m_cyc_i = 4'b0000;
        end
        tick();

        // Single request from master 2, ack and ack+err routing
        exp_q.push_back(4'b0100);
        m_cyc_i = 4'b0100;
        m_stb_i = 4'b0100;
        expect_grant("single", 1);
        s_ack_i = 1'b1;
        #1;
        check_val("single_ack", m_ack_o, 4'b0100);
        check_val("single_noerr", m_err_o, 4'b0000);
        s_err_i = 1'b1;
        #1;
        check_val("ackerr_err", m_err_o, 4'b0100);
        check_val("ackerr_ack", m_ack_o, 4'b0000);
        tick();
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        m_cyc_i = '0;
        tick();

        // No pre-emption: master 3 waits for master 1 to release
        exp_q.push_back(4'b0010);
        m_cyc_i = 4'b0010;
        m_stb_i = 4'b0010;
        expect_grant("owner1", 1);
        m_cyc_i = 4'b1010;
        m_stb_i = 4'b1010;
        tick();
        check_val("nopreempt_a", gnt_o, 4'b0010);
        tick();
        check_val("nopreempt_b", gnt_o, 4'b0010);
        s_ack_i = 1'b1;
        #1;
        check_val("nopreempt_ack", m_ack_o, 4'b0010);
        s_ack_i = 1'b0;
        exp_q.push_back(4'b1000);
        m_cyc_i = 4'b1000;
        m_stb_i = 4'b1000;
        expect_grant("handover", 2);
        m_cyc_i = '0;
        tick();

        // Stall watchdog on master 0
        exp_q.push_back(4'b0001);
        m_cyc_i = 4'b0001;
        m_stb_i = 4'b0001;
        expect_grant("stall", 1);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 0; c < 7; c++) tick();
        check_val("stall_pre_gnt", gnt_o, 4'b0001);
        check_val("stall_pre_to", timeout_o, 0);
        tick();
        check_val("term_timeout", timeout_o, 1);
        check_val("term_err", m_err_o, 4'b0001);
        check_val("term_gnt", gnt_o, 0);
        check_val("term_s_cyc", s_cyc_o, 0);
        tick();
        check_val("post_term_to", timeout_o, 0);
        check_val("post_term_err", m_err_o, 0);
        check_val("post_term_gnt", gnt_o, 0);
        exp_q.push_back(4'b0010);
        m_cyc_i = 4'b0011;
        m_stb_i = 4'b0011;
        expect_grant("after_term", 1);
`else
        for (int c = 0; c < 20; c++) tick();
        check_val("nostall_gnt", gnt_o, 4'b0001);
        check_val("nostall_to", timeout_o, 0);
        check_val("nostall_err", m_err_o, 0);
`endif

        // Reset in the middle of a strobed transfer
        check_val("pre_rst_stb", s_stb_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_s_cyc", s_cyc_o, 0);
        check_val("midrst_s_stb", s_stb_o, 0);
        check_val("midrst_gnt", gnt_o, 0);
        check_val("midrst_err", m_err_o, 0);
        check_val("midrst_to", timeout_o, 0);
        tick();
        exp_q.push_back(4'b0001);
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        rst_n   = 1'b1;
        expect_grant("post_rst", 1);
        m_cyc_i = '0;
        tick();
        tick();

        check_val("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 4, meaning number of Wishbone masters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning the number of stalled cycles before forced termination (range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port m_cyc_i, input, NUM_M bits: per-master bus request (Wishbone CYC).
REQ-006 SHALL have port m_stb_i, input, NUM_M bits: per-master strobe.
REQ-007 SHALL have port m_ack_o, output, NUM_M bits: acknowledge routed to the owner only.
REQ-008 SHALL have port m_err_o, output, NUM_M bits: error routed to the owner only.
REQ-009 SHALL have port gnt_o, output, NUM_M bits: one-hot grant, registered.
REQ-010 SHALL have port owner_o, output, $clog2(NUM_M) bits: index of the current owner, for the external address/data mux.
REQ-011 SHALL have ports s_cyc_o and s_stb_o, output, 1 bit each: cycle and strobe forwarded to the slave.
REQ-012 SHALL have ports s_ack_i and s_err_i, input, 1 bit each: slave response.
REQ-013 SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a transfer is force-terminated.

Function
REQ-014 SHALL implement the FSM states IDLE, GRANT and TERM; the state register is the sole source of gnt_o validity.
REQ-015 IDLE -> GRANT when any m_cyc_i bit is high; the winner is latched and gnt_o goes high on the next edge (1-cycle latency).
REQ-016 Arbitration SHALL be round-robin: search starts at last_owner+1 and wraps modulo NUM_M; last_owner updates on every grant.
REQ-017 GRANT -> IDLE when m_cyc_i[owner] is low; gnt_o clears on that edge, and a new grant requires one IDLE cycle (no back-to-back handover).
REQ-018 In GRANT: s_cyc_o = m_cyc_i[owner], s_stb_o = m_stb_i[owner], m_ack_o[owner] = s_ack_i, m_err_o[owner] = s_err_i (combinational); all other bits are 0.
REQ-019 In IDLE and TERM: s_cyc_o, s_stb_o, m_ack_o and gnt_o SHALL be 0.
REQ-020 Requests from non-owners during GRANT SHALL be ignored; no pre-emption.
REQ-021 If s_ack_i and s_err_i are both high, the err is forwarded and the ack is suppressed.
REQ-022 With multiple simultaneous requests, exactly one bit of gnt_o SHALL be set; a one-hot violation is a design error.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, gnt_o=0, owner_o=0, last_owner=NUM_M-1 (master 0 wins first), stall counter=0, timeout_o=0.
REQ-024 Reset asserted mid-transfer SHALL drop s_cyc_o in the same cycle, with no error pulse to the master.

Configuration
REQ-025 With macro WB_ARB_TIMEOUT_EN defined, a stall counter SHALL increment each GRANT cycle with s_stb_o=1 and s_ack_i=s_err_i=0, and clear on ack, err or state exit.
REQ-026 With WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 the FSM SHALL go GRANT -> TERM; TERM lasts 1 cycle, drives m_err_o[owner]=1 and timeout_o=1, then goes to IDLE; last_owner = the terminated master.
REQ-027 Without WB_ARB_TIMEOUT_EN, the counter and TERM state SHALL be absent, timeout_o SHALL be tied to 0, and GRANT may persist indefinitely.

Verification
REQ-028 Reset release, m_cyc_i=4'b1111 held -> gnt_o sequence 0001, 0010, 0100, 1000, 0001 with each master dropping cyc after 1 ack; one IDLE cycle between grants.
REQ-029 m_cyc_i=4'b0100 at cycle N -> gnt_o=0100 and owner_o=2 at N+1; s_ack_i pulse -> m_ack_o=0100 in the same cycle.
REQ-030 Owner 1 in GRANT, m_cyc_i[3] rises -> gnt_o stays 0010 until m_cyc_i[1] falls, then 1000 two edges later.
REQ-031 WB_ARB_TIMEOUT_EN defined, TIMEOUT=8, owner 0 strobing, no ack -> TERM after 8 stalled cycles, m_err_o=0001 and timeout_o=1 for 1 cycle, then IDLE, next grant to master 1 if requesting.
REQ-032 Assert rst_n low during GRANT with s_stb_o=1 -> s_cyc_o, gnt_o and m_err_o are 0 immediately; after release, master 0 is granted first.
REQ-033 s_ack_i=1 and s_err_i=1 together -> m_err_o[owner]=1 and m_ack_o=0.
